// File: rtl/sync_memory_module.sv
// Single-port synchronous RAM with req/ack handshake, programmable wait states and registered read data.
// Optional build macro MEM_CLEAR_EN adds a 'clear' input that zero-fills the whole array.
module sync_memory_module #(
   parameter int    DATA_WIDTH  = 8,
   parameter int    ADDR_WIDTH  = 4,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef MEM_CLEAR_EN
   input  logic                  clear,
`endif
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  ack,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WAIT   = 3'd1;
   localparam logic [2:0] ACCESS = 3'd2;
   localparam logic [2:0] DONE   = 3'd3;
`ifdef MEM_CLEAR_EN
   localparam logic [2:0] CLEAR  = 3'd4;
`endif

   logic [2:0]            state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  mem_wr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;

`ifdef MEM_CLEAR_EN
   logic [ADDR_WIDTH-1:0] clr_addr;
`endif

   // Write port is decoded from the current state, so an async reset aborts any pending write.
   always_comb begin
      mem_wr   = (state == ACCESS) && we_q;
      mem_addr = addr_q;
      mem_data = data_q;
`ifdef MEM_CLEAR_EN
      if (state == CLEAR) begin
         mem_wr   = 1'b1;
         mem_addr = clr_addr;
         mem_data = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[mem_addr] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         data_q   <= '0;
         data_out <= '0;
         ack      <= 1'b0;
         busy     <= 1'b0;
`ifdef MEM_CLEAR_EN
         clr_addr <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef MEM_CLEAR_EN
               if (clear) begin
                  busy     <= 1'b1;
                  clr_addr <= '0;
                  state    <= CLEAR;
               end else
`endif
               if (req) begin
                  addr_q <= address;
                  we_q   <= we;
                  data_q <= data_in;
                  busy   <= 1'b1;
                  cnt    <= 4'(WAIT_STATES);
                  state  <= (WAIT_STATES > 0) ? WAIT : ACCESS;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  data_out <= mem[addr_q];
               end
               ack   <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               ack   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
`ifdef MEM_CLEAR_EN
            CLEAR: begin
               if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                  ack   <= 1'b1;
                  state <= DONE;
               end else begin
                  clr_addr <= clr_addr + ADDR_WIDTH'(1);
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_memory_module.sv
// Self-checking bench for sync_memory_module: three instances (0, 2 and 3 wait states) share data inputs,
// each with its own req; a vector table plus hand-written sequences feed an expected-data scoreboard.
module tb_sync_memory_module;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req;
   logic       we;
   logic [3:0] address;
   logic [7:0] data_in;
   logic [7:0] dout [3];
   logic [2:0] ack;
   logic [2:0] busy;
`ifdef MEM_CLEAR_EN
   logic [2:0] clear;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] sb_q [$];

   typedef struct {
      int         dut;
      logic       w;
      logic [3:0] a;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [12];

   always #5 clk = ~clk;

   sync_memory_module #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
`ifdef MEM_CLEAR_EN
      .clear(clear[0]),
`endif
      .req(req[0]), .we(we), .address(address), .data_in(data_in),
      .data_out(dout[0]), .ack(ack[0]), .busy(busy[0]));

   sync_memory_module #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
`ifdef MEM_CLEAR_EN
      .clear(clear[1]),
`endif
      .req(req[1]), .we(we), .address(address), .data_in(data_in),
      .data_out(dout[1]), .ack(ack[1]), .busy(busy[1]));

   sync_memory_module #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(3)) dut2 (
      .clk(clk), .rst_n(rst_n),
`ifdef MEM_CLEAR_EN
      .clear(clear[2]),
`endif
      .req(req[2]), .we(we), .address(address), .data_in(data_in),
      .data_out(dout[2]), .ack(ack[2]), .busy(busy[2]));

   function automatic int ws_of(input int d);
      case (d)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pop_exp();
      if (sb_q.size() == 0) return 8'hxx;
      return sb_q.pop_front();
   endfunction

   // One complete access: drive, wait for ack, then verify latency, data, pulse width and busy span.
   task automatic apply_stimulus(input int d, input logic w, input logic [3:0] a,
                                 input logic [7:0] din, input logic [7:0] exp_dout, input int ws);
      int k;
      int busy_cnt;
      bit got;
      @(negedge clk);
      we = w; address = a; data_in = din; req[d] = 1'b1;
      sb_q.push_back(exp_dout);
      @(posedge clk);
      @(negedge clk);
      req[d] = 1'b0;
      k = 0; busy_cnt = 0; got = 1'b0;
      while (!got && k < 40) begin
         if (busy[d]) busy_cnt++;
         if (ack[d]) got = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      check_output("ack_seen", 32'(got), 32'd1);
      if (got) begin
         check_output("ack_latency", k, ws + 1);
         check_output("data_out", dout[d], pop_exp());
         check_output("busy_cycles", busy_cnt, ws + 2);
         @(negedge clk);
         check_output("ack_one_cycle", ack[d], 1'b0);
         check_output("busy_released", busy[d], 1'b0);
      end else begin
         void'(pop_exp());
      end
   endtask

   // A write request raised while busy must be dropped, not queued.
   task automatic busy_ignore_seq();
      int acks;
      @(negedge clk);
      we = 1'b0; address = 4'd3; data_in = 8'h00; req[0] = 1'b1;
      sb_q.push_back(8'hA5);
      @(posedge clk);
      @(negedge clk);
      check_output("busy_after_accept", busy[0], 1'b1);
      we = 1'b1; address = 4'd3; data_in = 8'hFF;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) req[0] = 1'b0;
         if (ack[0]) begin
            acks++;
            if (acks == 1) check_output("ignore_read_data", dout[0], pop_exp());
         end
      end
      check_output("ignore_ack_count", acks, 1);
      sb_q.delete();
      apply_stimulus(0, 1'b0, 4'd3, 8'h00, 8'hA5, 0);
   endtask

   // Reset lands while a write sits in WAIT: outputs clear at once and the write never lands.
   task automatic reset_mid_wait_seq();
      int acks;
      @(negedge clk);
      we = 1'b1; address = 4'd5; data_in = 8'h77; req[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req[1] = 1'b0;
      check_output("wait_busy", busy[1], 1'b1);
      check_output("wait_dout_before_reset", dout[1], 8'h3C);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_busy", busy[1], 1'b0);
      check_output("rst_ack", ack[1], 1'b0);
      check_output("rst_dout", dout[1], 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack[1]) acks++;
      end
      check_output("rst_no_ack", acks, 0);
      apply_stimulus(1, 1'b0, 4'd5, 8'h00, 8'h3C, 2);
   endtask

   // req held high, address toggled between 0 and 1 after each completion.
   task automatic held_req_seq();
      int cyc;
      int prev;
      int n;
      logic [7:0] exp_v [2];
      exp_v[0] = 8'h11;
      exp_v[1] = 8'h22;
      @(negedge clk);
      we = 1'b0; address = 4'd0; req[0] = 1'b1;
      sb_q.push_back(exp_v[0]);
      cyc = 0; prev = 0; n = 0;
      while (n < 6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (ack[0]) begin
            check_output("held_data", dout[0], pop_exp());
            if (n > 0) check_output("held_ack_period", cyc - prev, 3);
            prev = cyc;
            n++;
            if (n < 6) begin
               address = 4'(n % 2);
               sb_q.push_back(exp_v[n % 2]);
            end else begin
               req[0] = 1'b0;
            end
         end
      end
      req[0] = 1'b0;
      check_output("held_ack_count", n, 6);
      sb_q.delete();
      repeat (4) @(negedge clk);
   endtask

`ifdef MEM_CLEAR_EN
   task automatic clear_seq();
      int k;
      int busy_cnt;
      bit got;
      @(negedge clk);
      clear[0] = 1'b1; req[0] = 1'b1; we = 1'b1; address = 4'd2; data_in = 8'h55;
      @(posedge clk);
      @(negedge clk);
      clear[0] = 1'b0; req[0] = 1'b0;
      k = 0; busy_cnt = 0; got = 1'b0;
      while (!got && k < 60) begin
         if (busy[0]) busy_cnt++;
         if (ack[0]) got = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      check_output("clear_ack_seen", 32'(got), 32'd1);
      check_output("clear_latency", k, 16);
      check_output("clear_busy_cycles", busy_cnt, 17);
      @(negedge clk);
      check_output("clear_ack_one_cycle", ack[0], 1'b0);
      for (int a = 0; a < 16; a++) begin
         apply_stimulus(0, 1'b0, 4'(a), 8'h00, 8'h00, 0);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{0, 1'b1, 4'd3,  8'hA5, 8'h00};
      vecs[1]  = '{0, 1'b0, 4'd3,  8'h00, 8'hA5};
      vecs[2]  = '{0, 1'b1, 4'd0,  8'h11, 8'hA5};
      vecs[3]  = '{0, 1'b1, 4'd1,  8'h22, 8'hA5};
      vecs[4]  = '{0, 1'b0, 4'd0,  8'h00, 8'h11};
      vecs[5]  = '{0, 1'b0, 4'd1,  8'h00, 8'h22};
      vecs[6]  = '{2, 1'b1, 4'd12, 8'h0B, 8'h00};
      vecs[7]  = '{2, 1'b0, 4'd12, 8'h00, 8'h0B};
      vecs[8]  = '{2, 1'b1, 4'd7,  8'hC3, 8'h0B};
      vecs[9]  = '{2, 1'b0, 4'd7,  8'h00, 8'hC3};
      vecs[10] = '{1, 1'b1, 4'd5,  8'h3C, 8'h00};
      vecs[11] = '{1, 1'b0, 4'd5,  8'h00, 8'h3C};

      rst_n = 1'b0; req = '0; we = 1'b0; address = '0; data_in = '0;
`ifdef MEM_CLEAR_EN
      clear = '0;
`endif
      #1;
      for (int d = 0; d < 3; d++) begin
         check_output("reset_ack", ack[d], 1'b0);
         check_output("reset_busy", busy[d], 1'b0);
         check_output("reset_dout", dout[d], 8'h00);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         apply_stimulus(vecs[i].dut, vecs[i].w, vecs[i].a, vecs[i].din, vecs[i].exp, ws_of(vecs[i].dut));
      end

      busy_ignore_seq();
      reset_mid_wait_seq();
      held_req_seq();
`ifdef MEM_CLEAR_EN
      clear_seq();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
